// File: rtl/gate_sweep_pkg.sv
// Shared constants for the gate sweep controller: FSM encoding, gate bit
// positions within the 7-bit result vector, and sweep geometry.
package gate_sweep_pkg;

   localparam int NUM_GATES = 7;
   localparam int NUM_VECS  = 4;

   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NAND = 2;
   localparam int GATE_NOT  = 3;
   localparam int GATE_NOR  = 4;
   localparam int GATE_XOR  = 5;
   localparam int GATE_XNOR = 6;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef logic [NUM_GATES-1:0] gate_vec_t;

endpackage

// File: rtl/gate_ref_model.sv
// Truth-table model of the seven-gate unit: expected outputs for inputs a, b.
module gate_ref_model
   import gate_sweep_pkg::*;
(
   input  logic      a_i,
   input  logic      b_i,
   output gate_vec_t exp_o
);

   always_comb begin
      // NOTE: a full default first keeps every bit driven on every path, so no latch.
      exp_o            = '0;
      exp_o[GATE_AND]  = a_i & b_i;
      exp_o[GATE_OR]   = a_i | b_i;
      exp_o[GATE_NAND] = ~(a_i & b_i);
      exp_o[GATE_NOT]  = ~a_i;
      exp_o[GATE_NOR]  = ~(a_i | b_i);
      exp_o[GATE_XOR]  = a_i ^ b_i;
      exp_o[GATE_XNOR] = ~(a_i ^ b_i);
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps the gate unit through all four a/b combinations, samples after a
// settle time, and accumulates a per-gate error mask and mismatch count.
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int NUM_PASSES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a_out,
   output logic       b_out,
   input  logic [6:0] gate_res,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] err_mask,
   output logic [3:0] err_count,
   output logic [1:0] vec_idx
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
   localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);
   localparam logic [1:0] LAST_VEC  = 2'(NUM_VECS - 1);
   localparam logic [3:0] CNT_MAX   = 4'hF;

   logic [1:0] state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] settle_q, settle_d;
   logic [1:0] pcnt_q, pcnt_d;
   gate_vec_t  mask_q, mask_d;
   logic [3:0] cnt_q, cnt_d;
   logic       pass_q, pass_d;
   gate_vec_t  expected;
   gate_vec_t  mism;

   // Vector index doubles as the stimulus: bit0 -> a, bit1 -> b.
   assign a_out     = vec_q[0];
   assign b_out     = vec_q[1];
   assign vec_idx   = vec_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign err_mask  = mask_q;
   assign err_count = cnt_q;

   gate_ref_model u_ref (
      .a_i  (a_out),
      .b_i  (b_out),
      .exp_o(expected)
   );

   assign mism = gate_res ^ expected;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      pcnt_d   = pcnt_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      case (state_q)
         ST_IDLE: begin
            vec_d = '0;
            if (start) begin
               mask_d   = '0;
               cnt_d    = '0;
               pass_d   = 1'b0;
               pcnt_d   = '0;
               settle_d = SETTLE_LD;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            settle_d = settle_q - 4'd1;
            if (settle_q <= 4'd1) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            mask_d = mask_q | mism;
            if (mism != '0 && cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
            if (vec_q == LAST_VEC && pcnt_q == LAST_PASS) begin
               // Pass must see this final CHECK's mismatches, hence mask_d.
               pass_d  = (mask_d == '0);
               state_d = ST_DONE;
            end else begin
               if (vec_q == LAST_VEC) pcnt_d = pcnt_q + 2'd1;
               vec_d    = vec_q + 2'd1;
               settle_d = SETTLE_LD;
               state_d  = ST_SETTLE;
            end
         end
         ST_DONE: begin
            vec_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         pcnt_q   <= '0;
         mask_q   <= '0;
         cnt_q    <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         pcnt_q   <= pcnt_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: three parameterisations, each driven by a faultable
// gate-unit model and checked every cycle against a timeline-based reference.
module tb_gate_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start    [3];
   logic       a_o      [3];
   logic       b_o      [3];
   logic [6:0] res      [3];
   logic       busy_o   [3];
   logic       done_o   [3];
   logic       pass_o   [3];
   logic [6:0] mask_o   [3];
   logic [3:0] cnt_o    [3];
   logic [1:0] vec_o    [3];
   logic [6:0] s0       [3];
   logic [6:0] s1       [3];
   logic [6:0] inv      [3];

   bit         act      [3];
   int         k        [3];
   logic [6:0] m_mask   [3];
   int         m_cnt    [3];
   bit         m_pass   [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gate_sweep_ctrl #(.SETTLE_CYC(2), .NUM_PASSES(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
      .gate_res(res[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .err_mask(mask_o[0]), .err_count(cnt_o[0]), .vec_idx(vec_o[0]));

   gate_sweep_ctrl #(.SETTLE_CYC(1), .NUM_PASSES(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
      .gate_res(res[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .err_mask(mask_o[1]), .err_count(cnt_o[1]), .vec_idx(vec_o[1]));

   gate_sweep_ctrl #(.SETTLE_CYC(15), .NUM_PASSES(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .a_out(a_o[2]), .b_out(b_o[2]),
      .gate_res(res[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
      .err_mask(mask_o[2]), .err_count(cnt_o[2]), .vec_idx(vec_o[2]));

   function automatic int settle_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   function automatic int passes_of(input int i);
      case (i)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int lat_of(input int i);
      return 4 * passes_of(i) * (settle_of(i) + 1) + 1;
   endfunction

   // Bit order {xnor,xor,nor,not,nand,or,and}.
   function automatic logic [6:0] truth(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~(a | b), ~a, ~(a & b), a | b, a & b};
   endfunction

   // Which vector the reference timeline says is applied in sweep cycle kk.
   function automatic int exp_vec(input int i, input bit aa, input int kk);
      if (!aa) return 0;
      if (kk == lat_of(i)) return 3;
      return ((kk - 1) / (settle_of(i) + 1)) % 4;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++)
         res[i] = ((truth(a_o[i], b_o[i]) & ~s0[i]) | s1[i]) ^ inv[i];
   end

   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act_v, exp_v, $time);
      end
   endtask

   // Reference: a sweep is a fixed timeline of lat_of(i) cycles after acceptance.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            act[i] <= 1'b0; k[i] <= 0; m_mask[i] <= '0; m_cnt[i] <= 0; m_pass[i] <= 1'b0;
         end else if (!act[i]) begin
            if (start[i]) begin
               act[i] <= 1'b1; k[i] <= 1; m_mask[i] <= '0; m_cnt[i] <= 0; m_pass[i] <= 1'b0;
            end
         end else begin
            if (k[i] < lat_of(i) && (k[i] - 1) % (settle_of(i) + 1) == settle_of(i)) begin
               logic [1:0] v;
               logic [6:0] mm;
               v  = 2'(exp_vec(i, 1'b1, k[i]));
               mm = res[i] ^ truth(v[0], v[1]);
               m_mask[i] <= m_mask[i] | mm;
               if (mm != '0) m_cnt[i] <= (m_cnt[i] >= 15) ? 15 : m_cnt[i] + 1;
               if (k[i] == lat_of(i) - 1) m_pass[i] <= ((m_mask[i] | mm) == '0);
            end
            if (k[i] == lat_of(i)) act[i] <= 1'b0;
            else k[i] <= k[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic [1:0] v;
         v = 2'(exp_vec(i, act[i], k[i]));
         check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(act[i]));
         check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(act[i] && k[i] == lat_of(i)));
         check($sformatf("vec_idx[%0d]", i), 32'(vec_o[i]), 32'(v));
         check($sformatf("a_out[%0d]", i), 32'(a_o[i]), 32'(v[0]));
         check($sformatf("b_out[%0d]", i), 32'(b_o[i]), 32'(v[1]));
         check($sformatf("pass[%0d]", i), 32'(pass_o[i]), 32'(m_pass[i]));
         check($sformatf("err_mask[%0d]", i), 32'(mask_o[i]), 32'(m_mask[i]));
         check($sformatf("err_count[%0d]", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
      end
   end

   // Starts a sweep on DUT i from an idle negedge; optionally re-pulses start in
   // cycles 3, 8 and the DONE cycle. Returns at the negedge after DONE.
   task automatic sweep(input int i, input int exp_lat, input bit repulse);
      int n;
      n = 0;
      start[i] = 1'b1;
      @(posedge clk);
      #1 start[i] = 1'b0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (done_o[i]) break;
         start[i] = repulse && (n == 3 || n == 8);
      end
      check($sformatf("latency[%0d]", i), 32'(n), 32'(exp_lat));
      start[i] = repulse;
      @(posedge clk);
      #1 start[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_result(input string tag, input int i, input logic [6:0] mask,
                               input int cnt, input bit ps);
      check({tag, " err_mask"},  32'(mask_o[i]), 32'(mask));
      check({tag, " err_count"}, 32'(cnt_o[i]),  32'(cnt));
      check({tag, " pass"},      32'(pass_o[i]), 32'(ps));
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; s0[i] = '0; s1[i] = '0; inv[i] = '0;
      end
      repeat (2) @(negedge clk);
      check_result("reset", 0, 7'h00, 0, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      sweep(0, 13, 1'b0);
      check_result("golden", 0, 7'h00, 0, 1'b1);

      s0[0] = 7'b0100000;
      sweep(0, 13, 1'b0);
      check_result("xor_sa0", 0, 7'b0100000, 2, 1'b0);

      inv[1] = 7'b0001000;
      sweep(1, 25, 1'b0);
      check_result("not_inv", 1, 7'b0001000, 12, 1'b0);

      sweep(0, 13, 1'b1);
      check_result("repulse", 0, 7'b0100000, 2, 1'b0);
      s0[0] = '0;
      sweep(0, 13, 1'b0);
      check_result("after_repulse", 0, 7'h00, 0, 1'b1);

      // Reset with start high in cycle 6 of a faulty sweep.
      s1[0] = 7'b0000001;
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1; start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      @(negedge clk);
      check("rst busy", 32'(busy_o[0]), 32'd0);
      check("rst done", 32'(done_o[0]), 32'd0);
      check_result("rst", 0, 7'h00, 0, 1'b0);
      rst = 1'b0;
      s1[0] = '0;
      @(negedge clk);
      sweep(0, 13, 1'b0);
      check_result("post_rst", 0, 7'h00, 0, 1'b1);

      for (int r = 0; r < 20; r++) begin
         s0[0] = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
         s1[0] = 7'($urandom_range(0, 127) & $urandom_range(0, 127)) & ~s0[0];
         inv[0] = 7'($urandom_range(0, 127) & $urandom_range(0, 127) & $urandom_range(0, 127));
         sweep(0, 13, r[0]);
         check("per_sweep count<=4", 32'(cnt_o[0] <= 4'd4), 32'd1);
      end

      inv[2] = 7'h7F;
      sweep(2, 257, 1'b0);
      check_result("saturate", 2, 7'h7F, 15, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
